// File: rtl/nes_vid_pkg.sv
// rtl/nes_vid_pkg.sv - shared constants, FSM state type and FIFO entry layout for nes_vid2axis
package nes_vid_pkg;

  // Pixel width: {R,4'b0,G,4'b0,B,4'b0}
  localparam int PIX_W = 36;

  // Frame capture states
  typedef enum logic [1:0] {
    SEARCH,
    ARMED,
    ACTIVE
  } vid_state_e;

  // FIFO entry is {tuser, tlast, tdata}
  localparam int TLAST_BIT = PIX_W;
  localparam int TUSER_BIT = PIX_W + 1;
  localparam int ENTRY_W   = PIX_W + 2;

endpackage

// File: rtl/nes_sfifo.sv
// rtl/nes_sfifo.sv - generic single-clock first-word-fall-through FIFO
module nes_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  // Head entry falls through; zero when empty so outputs are clean after reset
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage array, written only when there is room
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nes_vid2axis.sv
// rtl/nes_vid2axis.sv - raster to AXI4-Stream video bridge; optional line check under NES_VID2AXIS_LINECHK_EN
module nes_vid2axis
  import nes_vid_pkg::*;
#(
  parameter int H_ACTIVE   = 1920,
  parameter int FIFO_DEPTH = 16,
  parameter int DW         = PIX_W
) (
  input  logic          clk_pixel,
  input  logic          rst_pixel_n,
  input  logic          de,
  input  logic          hsync,
  input  logic          vsync,
  input  logic [DW-1:0] video,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tuser,
  output logic          m_axis_tlast,
  output logic          locked,
  output logic          overflow,
  input  logic          clr_err,
  output logic          line_err
);

  localparam logic [11:0] H_LAST = 12'(H_ACTIVE - 1);

  logic          s_de;
  logic          s_de_d;
  logic          s_vsync;
  logic          s_vsync_d;
  logic [DW-1:0] s_video;

  vid_state_e    state;
  vid_state_e    state_nxt;
  logic          sof;

  logic          vs_rise;
  logic          tlast_nxt;
  logic          wr_req;
  logic          wr_ok;
  logic          ovf_evt;

  logic [DW+1:0] wr_data;
  logic [DW+1:0] rd_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // Input staging register; one cycle of lookahead on de gives tlast
  always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
    if (!rst_pixel_n) begin
      s_de      <= 1'b0;
      s_de_d    <= 1'b0;
      s_vsync   <= 1'b0;
      s_vsync_d <= 1'b0;
      s_video   <= '0;
    end else begin
      s_de      <= de;
      s_de_d    <= s_de;
      s_vsync   <= vsync;
      s_vsync_d <= s_vsync;
      s_video   <= video;
    end
  end

  assign vs_rise   = s_vsync && !s_vsync_d;
  assign tlast_nxt = s_de && !de;
  assign wr_req    = s_de && (state != SEARCH);
  // Full is judged on the registered count, so a same-cycle pop cannot save the write
  assign ovf_evt   = wr_req && fifo_full;
  assign wr_ok     = wr_req && !fifo_full;
  assign locked    = (state != SEARCH);

  always_comb begin
    wr_data            = '0;
    wr_data[DW-1:0]    = s_video;
    wr_data[TLAST_BIT] = tlast_nxt;
    wr_data[TUSER_BIT] = sof;
  end

  // FSM state register
  always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
    if (!rst_pixel_n) state <= SEARCH;
    else              state <= state_nxt;
  end

  // Next state: vsync arms capture, first pixel starts it, overflow abandons the frame
  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (vs_rise) state_nxt = ARMED;
      ARMED:   if (!vs_rise && wr_ok) state_nxt = ACTIVE;
      ACTIVE:  if (vs_rise) state_nxt = ARMED;
      default: state_nxt = SEARCH;
    endcase
    if (ovf_evt) state_nxt = SEARCH;
  end

  // Start-of-frame marker: raised when arming, consumed by the first written pixel
  always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
    if (!rst_pixel_n)             sof <= 1'b0;
    else if (vs_rise && !ovf_evt) sof <= 1'b1;
    else if (wr_ok)               sof <= 1'b0;
  end

  // Sticky overflow flag; clear wins over a coincident set
  always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
    if (!rst_pixel_n) overflow <= 1'b0;
    else if (clr_err) overflow <= 1'b0;
    else if (ovf_evt) overflow <= 1'b1;
  end

  nes_sfifo #(
    .WIDTH (DW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_pixel),
    .rst_n   (rst_pixel_n),
    .wr_en   (wr_ok),
    .wr_data (wr_data),
    .rd_en   (m_axis_tready),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = rd_data[DW-1:0];
  assign m_axis_tlast  = rd_data[TLAST_BIT];
  assign m_axis_tuser  = rd_data[TUSER_BIT];

`ifdef NES_VID2AXIS_LINECHK_EN
  logic [11:0] pix_cnt;
  logic        s_hsync;
  logic        s_hsync_d;
  logic        hs_rise;

  assign hs_rise = s_hsync && !s_hsync_d;

  // Stage hsync alongside the pixel so its edge lines up with the staged data
  always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
    if (!rst_pixel_n) begin
      s_hsync   <= 1'b0;
      s_hsync_d <= 1'b0;
    end else begin
      s_hsync   <= hsync;
      s_hsync_d <= s_hsync;
    end
  end

  // Count written pixels per line and flag a line whose length is not H_ACTIVE
  always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
    if (!rst_pixel_n) begin
      pix_cnt  <= '0;
      line_err <= 1'b0;
    end else begin
      if (wr_ok && tlast_nxt) pix_cnt <= '0;
      else if (hs_rise)       pix_cnt <= '0;
      else if (wr_ok)         pix_cnt <= pix_cnt + 1'b1;

      if (clr_err)                                     line_err <= 1'b0;
      else if (wr_ok && tlast_nxt && pix_cnt != H_LAST) line_err <= 1'b1;
    end
  end

  logic unused_sigs;
  assign unused_sigs = ^{s_de_d, fifo_count};
`else
  assign line_err = 1'b0;

  logic unused_sigs;
  assign unused_sigs = ^{s_de_d, fifo_count, hsync, H_LAST};
`endif

endmodule
